background_scaler: RTL and testbench
====================================

BACKGROUND_SCALER -- requirements
Module: background_scaler

Interface
REQ-001 Parameter SRC_W, default 640: source image width in texels, legal range 1..640.
REQ-002 Parameter SRC_H, default 480: source image height in texels, legal range 1..480.
REQ-003 Parameter IDX_BITS, default 1: width of the palette index stored in the ROM.
REQ-004 Parameter ADDR_BITS, default 19: ROM address width; SHALL be at least clog2(SRC_W*SRC_H).
REQ-005 vga_clk  in  1  pixel clock; only clock in the block, all state on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 DrawX  in  10  current screen column 0..639; advances by 1 per vga_clk within a line.
REQ-008 DrawY  in  10  current screen row 0..479.
REQ-009 blank  in  1  1 = active video, 0 = blanking.
REQ-010 rom_address  out  ADDR_BITS  texel address to a synchronous ROM with 1-cycle read latency.
REQ-011 rom_q  in  IDX_BITS  palette index returned by the ROM.
REQ-012 pal_index  out  IDX_BITS  index to the external combinational palette; equals rom_q.
REQ-013 pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_index.
REQ-014 red, green, blue  out  4 each  registered pixel colour.
REQ-015 sync_err  out  1  sticky flag for a DrawX sequence violation.

Function
REQ-016 Mapping SHALL be sx = floor(DrawX*SRC_W/640) and sy = floor(DrawY*SRC_H/480); rom_address = sy*SRC_W + sx.
REQ-017 No multiplier or divider SHALL be used; the mapping is computed with incremental accumulators xacc, yacc, row_base and sx, sy.
REQ-018 When DrawX==0, xacc and sx SHALL load 0.
REQ-019 On every other cycle, xacc += SRC_W; if the result is >= 640, subtract 640 and increment sx (at most once per cycle).
REQ-020 A new line is detected when DrawX==0 and DrawY differs from its registered previous value.
REQ-021 On a new line, yacc += SRC_H; on wrap past 480, subtract 480, increment sy and add SRC_W to row_base.
REQ-022 When DrawX==0 and DrawY==0, yacc, sy and row_base SHALL load 0 (frame restart; this overrides REQ-021).
REQ-023 rom_address SHALL be registered and valid 1 cycle after the DrawX/DrawY sample (cycle N+1).
REQ-024 rom_q is consumed at N+2; red/green/blue SHALL register the palette colour at N+3.
REQ-025 blank SHALL be delayed 3 cycles in a shift register aligned with the colour path.
REQ-026 When the delayed blank is 0, red/green/blue SHALL load 0.
REQ-027 If DrawX != 0 and DrawX != previous DrawX+1, sync_err SHALL set and stay set until reset.
REQ-028 On a sequence violation, the accumulators SHALL keep stepping and SHALL resynchronise at the next DrawX==0.
REQ-029 sx SHALL never exceed SRC_W-1 and sy SHALL never exceed SRC_H-1 for in-range DrawX/DrawY.
REQ-030 At column 639 the accumulator state SHALL hold until DrawX==0; DrawY jumping 479->0 SHALL be handled by the frame restart.

Reset
REQ-031 Asserting reset SHALL asynchronously clear rom_address, red, green, blue, sync_err, all accumulators, the blank pipeline and the previous-DrawY register to 0.
REQ-032 After a mid-frame reset, the outputs are 0 until the blank pipeline refills.
REQ-033 After a mid-frame reset, address tracking resumes correctly from the next DrawX==0.

Configuration
REQ-034 Macro BG_SCROLL_EN, when defined, SHALL add input scroll_x[9:0].
REQ-035 With BG_SCROLL_EN, scroll_x is sampled only at frame restart (DrawX==0, DrawY==0).
REQ-036 With BG_SCROLL_EN, the effective column SHALL be (sx + scroll) mod SRC_W, computed by compare-and-subtract.
REQ-037 With BG_SCROLL_EN, a sampled scroll_x >= SRC_W SHALL be treated as 0.
REQ-038 Without BG_SCROLL_EN, scroll_x SHALL be absent and the offset is 0; behaviour is identical to REQ-016.

Verification
REQ-039 SRC_W=640, SRC_H=480, raster to (639,479) -> rom_address=307199 at N+1; identity mapping at every pixel.
REQ-040 SRC_W=320, SRC_H=240, (DrawX,DrawY)=(5,3) -> rom_address=1*320+2=322.
REQ-041 rom_q=1, palette colour F/0/0, blank=1 -> red=F at N+3; blank=0 -> 0/0/0 at N+3.
REQ-042 Reset pulse at (300,200) -> all outputs 0 immediately; next line addresses correct, sync_err=0.
REQ-043 DrawX sequence 10 then 12 -> sync_err=1 held; addresses correct again after the next DrawX==0.
REQ-044 BG_SCROLL_EN, SRC_W=320, scroll_x=100, DrawX=600 -> column (300+100)-320=80; scroll_x=400 -> column 300.

Source files
------------

// File: rtl/background_scaler.sv
// background_scaler: maps the 640x480 raster onto a SRC_W x SRC_H texel ROM with add/compare accumulators and registers the palette colour.
// Optional feature: define BG_SCROLL_EN to add input scroll_x, a per-frame horizontal texel offset.
module background_scaler #(
  parameter int SRC_W = 640,
  parameter int SRC_H = 480,
  parameter int IDX_BITS = 1,
  parameter int ADDR_BITS = 19
) (
  input  logic                 vga_clk,
  input  logic                 reset,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic                 blank,
`ifdef BG_SCROLL_EN
  input  logic [9:0]           scroll_x,
`endif
  output logic [ADDR_BITS-1:0] rom_address,
  input  logic [IDX_BITS-1:0]  rom_q,
  output logic [IDX_BITS-1:0]  pal_index,
  input  logic [3:0]           pal_red,
  input  logic [3:0]           pal_green,
  input  logic [3:0]           pal_blue,
  output logic [3:0]           red,
  output logic [3:0]           green,
  output logic [3:0]           blue,
  output logic                 sync_err
);
  localparam logic [10:0] W = 11'(SRC_W);
  localparam logic [10:0] H = 11'(SRC_H);
  logic [9:0] xacc, xacc_n, sx, sx_n, prev_x, prev_y, prev_y_n, col;
  logic [8:0] yacc, yacc_n, sy, sy_n;
  logic [10:0] xsum, ysum;
  logic [ADDR_BITS-1:0] row_base, row_base_n;
  logic x_valid, restart, step_x, step_y, x_wrap, y_wrap;
  logic [1:0] blank_d;
  assign pal_index = rom_q;
  assign restart = DrawX == 10'd0 && DrawY == 10'd0;
  // Columns past 639 (or a repeated 639) never step, so the state holds until DrawX returns to 0.
  assign step_x = DrawX != 10'd0 && DrawX < 10'd640 && prev_x < 10'd639;
  // prev_y is the row the y accumulators represent; it normally advances at DrawX==0, and after a
  // mid-frame reset it catches up one row per cycle so the following line is addressed correctly.
  assign step_y = !restart && DrawY > prev_y && DrawY < 10'd480;
  assign xsum = {1'b0, xacc} + W;
  assign ysum = {2'b0, yacc} + H;
  assign x_wrap = xsum >= 11'd640;
  assign y_wrap = ysum >= 11'd480;
`ifdef BG_SCROLL_EN
  logic [9:0] scroll, scroll_n;
  logic [10:0] csum;
  assign scroll_n = restart ? ({1'b0, scroll_x} < W ? scroll_x : 10'd0) : scroll;
  assign csum = {1'b0, sx_n} + {1'b0, scroll_n};
  assign col = csum >= W ? 10'(csum - W) : csum[9:0];
`else
  assign col = sx_n;
`endif
  // Next accumulator state for the pixel currently on DrawX/DrawY.
  always_comb begin
    xacc_n = DrawX == 10'd0 ? 10'd0 : step_x ? (x_wrap ? 10'(xsum - 11'd640) : xsum[9:0]) : xacc;
    sx_n = DrawX == 10'd0 ? 10'd0 : step_x && x_wrap ? sx + 10'd1 : sx;
    yacc_n = restart ? 9'd0 : step_y ? (y_wrap ? 9'(ysum - 11'd480) : ysum[8:0]) : yacc;
    sy_n = restart ? 9'd0 : step_y && y_wrap ? sy + 9'd1 : sy;
    row_base_n = restart ? '0 : step_y && y_wrap ? row_base + ADDR_BITS'(SRC_W) : row_base;
    prev_y_n = restart ? 10'd0 : step_y ? prev_y + 10'd1 : prev_y;
  end
  // Accumulator registers and the registered ROM address.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      xacc <= '0;
      sx <= '0;
      yacc <= '0;
      sy <= '0;
      row_base <= '0;
      prev_y <= '0;
      rom_address <= '0;
`ifdef BG_SCROLL_EN
      scroll <= '0;
`endif
    end else begin
      xacc <= xacc_n;
      sx <= sx_n;
      yacc <= yacc_n;
      sy <= sy_n;
      row_base <= row_base_n;
      prev_y <= prev_y_n;
      rom_address <= row_base_n + ADDR_BITS'(col);
`ifdef BG_SCROLL_EN
      scroll <= scroll_n;
`endif
    end
  end
  // Sticky DrawX sequence check; the first sample after reset has no predecessor to compare.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      prev_x <= '0;
      x_valid <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      prev_x <= DrawX;
      x_valid <= 1'b1;
      if (x_valid && DrawX != 10'd0 && DrawX != prev_x + 10'd1) sync_err <= 1'b1;
    end
  end
  // Blank travels two stages so it gates the colour register together with the ROM/palette data.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      blank_d <= '0;
      red <= '0;
      green <= '0;
      blue <= '0;
    end else begin
      blank_d <= {blank_d[0], blank};
      red <= blank_d[1] ? pal_red : 4'd0;
      green <= blank_d[1] ? pal_green : 4'd0;
      blue <= blank_d[1] ? pal_blue : 4'd0;
    end
  end
endmodule

// File: tb/tb_background_scaler.sv
// tb_background_scaler: scoreboard and spot-vector bench for two scaler instances (640x480 and 320x240).
module tb_background_scaler;
  typedef struct {int x; int y; int a; int b;} vec_t;
  typedef struct {logic chk; logic [11:0] ca; logic [11:0] cb;} exp_t;
  logic clk = 1'b0, reset = 1'b1, blank = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic [18:0] addr_a, addr_b;
  logic q_a = 1'b0, q_b = 1'b0, idx_a, idx_b, err_a, err_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic chk_en = 1'b0, err_exp = 1'b0;
  int checks = 0, errors = 0;
  vec_t tbl[8];
  exp_t colq[$];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    q_a <= addr_a[0];
    q_b <= addr_b[0];
  end
  background_scaler dut_a (
    .vga_clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
`ifdef BG_SCROLL_EN
    .scroll_x(10'd0),
`endif
    .rom_address(addr_a), .rom_q(q_a), .pal_index(idx_a),
    .pal_red(idx_a ? 4'hF : 4'h0), .pal_green(idx_a ? 4'h0 : 4'h5), .pal_blue(idx_a ? 4'hA : 4'h3),
    .red(r_a), .green(g_a), .blue(b_a), .sync_err(err_a)
  );
  background_scaler #(.SRC_W(320), .SRC_H(240), .IDX_BITS(1), .ADDR_BITS(19)) dut_b (
    .vga_clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
`ifdef BG_SCROLL_EN
    .scroll_x(10'd0),
`endif
    .rom_address(addr_b), .rom_q(q_b), .pal_index(idx_b),
    .pal_red(idx_b ? 4'hF : 4'h0), .pal_green(idx_b ? 4'h0 : 4'h5), .pal_blue(idx_b ? 4'hA : 4'h3),
    .red(r_b), .green(g_b), .blue(b_b), .sync_err(err_b)
  );
  function automatic int exp_addr(input int x, input int y, input int w, input int h);
    return ((y * h) / 480) * w + (x * w) / 640;
  endfunction
  function automatic logic [11:0] exp_col(input logic idx, input logic b);
    return b ? (idx ? 12'hF0A : 12'h053) : 12'h000;
  endfunction
  function automatic logic blank_of(input int x, input int y);
    return !((y == 3 && x >= 100 && x < 110) || y >= 470);
  endfunction
  function automatic logic full_row(input int y);
    return y == 0 || y == 1 || y == 3 || y == 240 || y == 479;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s x=%0d y=%0d: got %0d expected %0d", name, DrawX, DrawY, act, exp);
    end
  endtask
  task automatic step(input int x, input int y, input logic b);
    exp_t e;
    int ea, eb;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    if (x == 0) chk_en = 1'b1;
    ea = exp_addr(x, y, 640, 480);
    eb = exp_addr(x, y, 320, 240);
    e.chk = chk_en;
    e.ca = exp_col(ea[0], b);
    e.cb = exp_col(eb[0], b);
    colq.push_back(e);
    @(posedge clk);
    #1;
    if (chk_en) begin
      check("addr_a", 32'(addr_a), 32'(ea));
      check("addr_b", 32'(addr_b), 32'(eb));
      foreach (tbl[i])
        if (tbl[i].x == x && tbl[i].y == y) begin
          check("vec_a", 32'(addr_a), 32'(tbl[i].a));
          check("vec_b", 32'(addr_b), 32'(tbl[i].b));
        end
    end
    check("sync_err_a", 32'(err_a), 32'(err_exp));
    check("sync_err_b", 32'(err_b), 32'(err_exp));
    if (colq.size() == 3) begin
      e = colq.pop_front();
      if (e.chk) begin
        check("colour_a", 32'({r_a, g_a, b_a}), 32'(e.ca));
        check("colour_b", 32'({r_b, g_b, b_b}), 32'(e.cb));
      end
    end
  endtask
  task automatic zero_outputs(input string name);
    check({name, "_addr_a"}, 32'(addr_a), 32'd0);
    check({name, "_addr_b"}, 32'(addr_b), 32'd0);
    check({name, "_rgb_a"}, 32'({r_a, g_a, b_a}), 32'd0);
    check({name, "_rgb_b"}, 32'({r_b, g_b, b_b}), 32'd0);
    check({name, "_err"}, 32'({err_a, err_b}), 32'd0);
  endtask
  initial begin
    tbl[0] = '{0, 0, 0, 0};
    tbl[1] = '{5, 3, 1925, 322};
    tbl[2] = '{639, 0, 639, 319};
    tbl[3] = '{639, 1, 1279, 319};
    tbl[4] = '{2, 1, 642, 1};
    tbl[5] = '{320, 240, 153920, 38560};
    tbl[6] = '{3, 479, 306563, 76481};
    tbl[7] = '{639, 479, 307199, 76799};
    repeat (3) @(posedge clk);
    #1;
    zero_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    for (int y = 0; y < 480; y++)
      for (int x = 0; x < (full_row(y) ? 640 : 4); x++) step(x, y, blank_of(x, y));
    for (int y = 0; y < 200; y++)
      for (int x = 0; x < 4; x++) step(x, y, 1'b1);
    for (int x = 0; x <= 300; x++) step(x, 200, 1'b1);
    #2 reset = 1'b1;
    #1 zero_outputs("mid_reset");
    #1 reset = 1'b0;
    colq.delete();
    chk_en = 1'b0;
    for (int x = 301; x < 640; x++) step(x, 200, 1'b1);
    for (int x = 0; x < 640; x++) step(x, 201, 1'b1);
    for (int x = 0; x <= 10; x++) step(x, 202, 1'b1);
    chk_en = 1'b0;
    err_exp = 1'b1;
    for (int x = 12; x < 640; x++) step(x, 202, 1'b1);
    for (int x = 0; x < 640; x++) step(x, 203, 1'b1);
    for (int y = 204; y < 480; y++)
      for (int x = 0; x < 4; x++) step(x, y, blank_of(x, y));
    for (int x = 0; x < 8; x++) step(x, 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
